// File: rtl/ip_codma_machine_states_pkg.sv
// Shared types for the CoDMA task queue: dispatcher state encoding and queue entry layout.
package ip_codma_machine_states_pkg;

  typedef enum logic [2:0] {
    TQ_IDLE,
    TQ_START,
    TQ_RUN,
    TQ_COMPLETE,
    TQ_ABORT
  } tq_state_t;

  typedef struct packed {
    logic [31:0] task_ptr;
    logic [31:0] status_ptr;
  } tq_entry_t;

endpackage

// File: rtl/ip_codma_tq_fifo.sv
// Circular descriptor FIFO with registered push_ready and a single-cycle flush.
module ip_codma_tq_fifo
  import ip_codma_machine_states_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  tq_entry_t                  wdata,
  output tq_entry_t                  rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       push_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  tq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [LW-1:0]   level_nxt;
  logic            do_push, do_pop;

  // push_ready already reflects full, so a push into a full queue is dropped
  // even when a pop frees a slot in the same cycle.
  assign do_push = push & push_ready & ~flush;
  assign do_pop  = pop & (level != '0) & ~flush;
  assign rdata   = mem[rd_idx];

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (do_push && !do_pop)
      level_nxt = level + LW'(1);
    else if (do_pop && !do_push)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      level      <= '0;
      push_ready <= 1'b1;
    end else begin
      if (flush) begin
        wr_idx <= '0;
        rd_idx <= '0;
      end else begin
        if (do_push) wr_idx <= wr_idx + AW'(1);
        if (do_pop)  rd_idx <= rd_idx + AW'(1);
      end
      level      <= level_nxt;
      push_ready <= (level_nxt != LW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/ip_codma_task_queue.sv
// CoDMA task queue: pops descriptors and sequences the CoDMA start/busy handshake.
// Optional start timeout enabled by defining CODMA_TQ_START_TIMEOUT_EN.
module ip_codma_task_queue
  import ip_codma_machine_states_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       push_i,
  output logic                       push_ready_o,
  input  logic [31:0]                push_task_ptr_i,
  input  logic [31:0]                push_status_ptr_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       start_o,
  output logic                       stop_o,
  output logic [31:0]                task_pointer_o,
  output logic [31:0]                status_pointer_o,
  input  logic                       busy_i,
  output logic [15:0]                done_cnt_o,
  output logic                       irq_o,
  output logic                       err_o
);

  tq_state_t   state, state_nxt;
  tq_entry_t   push_entry, head, cur;
  logic        pop;
  logic        tmo_hit;
  logic [15:0] done_cnt;

  assign push_entry = '{task_ptr: push_task_ptr_i, status_ptr: push_status_ptr_i};

  ip_codma_tq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_i),
    .reset      (reset_i),
    .flush      (flush_i),
    .push       (push_i),
    .pop        (pop),
    .wdata      (push_entry),
    .rdata      (head),
    .level      (level_o),
    .push_ready (push_ready_o)
  );

`ifdef CODMA_TQ_START_TIMEOUT_EN
  localparam int TW = $clog2(START_TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err;

  // Counts completed START cycles; the last allowed cycle is START_TIMEOUT-1.
  assign tmo_hit = (tmo_cnt == TW'(START_TIMEOUT - 1));
  assign err_o   = err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= (state == TQ_START) ? tmo_cnt + TW'(1) : '0;
      if (state == TQ_START && !flush_i && !busy_i && tmo_hit)
        err <= 1'b1;
    end
  end
`else
  logic tmo_unused;

  assign tmo_unused = ^START_TIMEOUT;
  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      TQ_IDLE: begin
        if (enable_i && level_o != '0 && !flush_i) begin
          pop       = 1'b1;
          state_nxt = TQ_START;
        end
      end
      TQ_START: begin
        if (flush_i)
          state_nxt = TQ_IDLE;
        else if (busy_i)
          state_nxt = TQ_RUN;
        else if (tmo_hit)
          state_nxt = TQ_IDLE;
      end
      TQ_RUN: begin
        if (flush_i)
          state_nxt = TQ_ABORT;
        else if (!busy_i)
          state_nxt = TQ_COMPLETE;
      end
      TQ_COMPLETE: state_nxt = TQ_IDLE;
      TQ_ABORT: begin
        if (!busy_i) state_nxt = TQ_IDLE;
      end
      default: state_nxt = TQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= TQ_IDLE;
      cur      <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Pointers hold until the next pop so CoDMA sees them stable for the whole task.
      if (pop) cur <= head;
      if (state == TQ_COMPLETE) done_cnt <= done_cnt + 16'd1;
    end
  end

  assign start_o          = (state == TQ_START);
  assign stop_o           = (state == TQ_ABORT);
  assign irq_o            = (state == TQ_COMPLETE);
  assign task_pointer_o   = cur.task_ptr;
  assign status_pointer_o = cur.status_ptr;
  assign done_cnt_o       = done_cnt;

endmodule

// File: tb/tb_ip_codma_task_queue.sv
// Directed bench for ip_codma_task_queue with a queue-based reference model checked every cycle.
module tb_ip_codma_task_queue;

  localparam int DEPTH         = 4;
  localparam int START_TIMEOUT = 16;

  typedef enum int {M_IDLE, M_START, M_RUN, M_CMP, M_ABORT} mph_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, push = 1'b0, flush = 1'b0, busy = 1'b0;
  logic [31:0] tptr = '0, sptr = '0;
  logic        push_ready, start_o, stop_o, irq_o, err_o;
  logic [2:0]  level;
  logic [31:0] task_pointer, status_pointer;
  logic [15:0] done_cnt;

  always #5 clk = ~clk;

  ip_codma_task_queue #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .enable_i          (enable),
    .push_i            (push),
    .push_ready_o      (push_ready),
    .push_task_ptr_i   (tptr),
    .push_status_ptr_i (sptr),
    .flush_i           (flush),
    .level_o           (level),
    .start_o           (start_o),
    .stop_o            (stop_o),
    .task_pointer_o    (task_pointer),
    .status_pointer_o  (status_pointer),
    .busy_i            (busy),
    .done_cnt_o        (done_cnt),
    .irq_o             (irq_o),
    .err_o             (err_o)
  );

  int vectors = 0, miscompares = 0;
  int start_hi = 0, irq_n = 0;
  bit chk_en = 0, preload = 0;

  // reference model state
  logic [63:0] mq[$];
  mph_t        mph = M_IDLE;
  logic [31:0] m_tp = '0, m_sp = '0;
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0, m_rdy = 1'b1;
  int          m_tmo = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        mph = M_IDLE; m_tp = '0; m_sp = '0; m_cnt = '0; m_err = 1'b0; m_rdy = 1'b1; m_tmo = 0;
      end else begin
        bit acc;
        acc = push && m_rdy && !flush;
        if (preload) m_cnt = 16'hFFFF;
        case (mph)
          M_IDLE:
            if (enable && mq.size() > 0 && !flush) begin
              {m_tp, m_sp} = mq.pop_front();
              mph = M_START; m_tmo = 0;
            end
          M_START:
            if (flush) mph = M_IDLE;
            else if (busy) mph = M_RUN;
            else begin
              m_tmo++;
`ifdef CODMA_TQ_START_TIMEOUT_EN
              if (m_tmo == START_TIMEOUT) begin m_err = 1'b1; mph = M_IDLE; end
`endif
            end
          M_RUN:
            if (flush) mph = M_ABORT;
            else if (!busy) mph = M_CMP;
          M_CMP: begin m_cnt = m_cnt + 16'd1; mph = M_IDLE; end
          M_ABORT: if (!busy) mph = M_IDLE;
          default: mph = M_IDLE;
        endcase
        if (flush) mq.delete();
        else if (acc) mq.push_back({tptr, sptr});
        m_rdy = (mq.size() != DEPTH);
      end
    end
  endtask

  task automatic compare();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("start_o",     start_o,        mph == M_START);
        chk("stop_o",      stop_o,         mph == M_ABORT);
        chk("irq_o",       irq_o,          mph == M_CMP);
        chk("level_o",     level,          mq.size());
        chk("push_ready",  push_ready,     m_rdy);
        chk("task_ptr",    task_pointer,   m_tp);
        chk("status_ptr",  status_pointer, m_sp);
        chk("done_cnt",    done_cnt,       m_cnt);
        chk("err_o",       err_o,          m_err);
        if (start_o) start_hi++;
        if (irq_o)   irq_n++;
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_one(input logic [31:0] t, input logic [31:0] s);
    push = 1'b1; tptr = t; sptr = s;
    step();
    push = 1'b0;
  endtask

  task automatic wait_start();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (start_o) begin ok = 1; break; end
      step();
    end
    chk("wait_start", ok, 1);
  endtask

  task automatic serve(input int rise, input int len);
    wait_start();
    step(rise); busy = 1'b1;
    step(len);  busy = 1'b0;
  endtask

  initial begin
    int s0, i0;
    fork
      model();
      compare();
      begin #200000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end
    join_none

    // reset state
    step(2);
    chk_en = 1;
    chk("rst level", level, 0);
    chk("rst push_ready", push_ready, 1);
    chk("rst done_cnt", done_cnt, 0);
    chk("rst start", start_o, 0);
    reset = 1'b0;
    step();

    // single task: start held 3 cycles, one irq
    enable = 1'b1;
    s0 = start_hi; i0 = irq_n;
    push_one(32'h40, 32'h0);
    serve(2, 10);
    step(5);
    chk("t1 start cycles", start_hi - s0, 3);
    chk("t1 irq pulses", irq_n - i0, 1);
    chk("t1 done_cnt", done_cnt, 1);
    chk("t1 task_ptr", task_pointer, 32'h40);

    // fill past full with dispatch disabled, then drain in order
    enable = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tptr = (i + 1) << 8; sptr = 32'h1000 + i;
      step();
    end
    push = 1'b0;
    chk("t2 level full", level, 4);
    chk("t2 push_ready full", push_ready, 0);
    i0 = irq_n;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start();
      chk("t2 fifo order task", task_pointer, (i + 1) << 8);
      chk("t2 fifo order status", status_pointer, 32'h1000 + i);
      step(); busy = 1'b1;
      step(3); busy = 1'b0;
    end
    step(5);
    chk("t2 dispatches", irq_n - i0, 4);
    chk("t2 done_cnt", done_cnt, 5);
    chk("t2 level empty", level, 0);

    // flush during RUN with two entries still queued
    enable = 1'b0;
    push_one(32'h500, 32'h504);
    push_one(32'h600, 32'h604);
    push_one(32'h700, 32'h704);
    i0 = irq_n;
    enable = 1'b1;
    wait_start();
    step(); busy = 1'b1;
    step(2);
    chk("t3 level before flush", level, 2);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3 level after flush", level, 0);
    chk("t3 stop asserted", stop_o, 1);
    step(3);
    chk("t3 stop held", stop_o, 1);
    busy = 1'b0;
    step();
    chk("t3 stop released", stop_o, 0);
    step(3);
    chk("t3 no irq", irq_n - i0, 0);
    chk("t3 done_cnt", done_cnt, 5);
    chk("t3 no restart", start_o, 0);

    // push+pop same cycle keeps level; flush+push in START empties and aborts start
    enable = 1'b0;
    push_one(32'h800, 32'h804);
    push_one(32'h900, 32'h904);
    i0 = irq_n;
    enable = 1'b1; push = 1'b1; tptr = 32'hA00; sptr = 32'hA04;
    step();
    push = 1'b0; enable = 1'b0;
    chk("t4 level push+pop", level, 2);
    chk("t4 start", start_o, 1);
    chk("t4 task_ptr", task_pointer, 32'h800);
    flush = 1'b1; push = 1'b1; tptr = 32'hB00;
    step();
    flush = 1'b0; push = 1'b0;
    chk("t4 level flushed", level, 0);
    chk("t4 start dropped", start_o, 0);
    step(3);
    chk("t4 no irq", irq_n - i0, 0);

    // counter wrap from a forced 0xFFFF
    @(negedge clk); #1;
    force dut.done_cnt = 16'hFFFF;
    preload = 1;
    @(posedge clk); #1;
    preload = 0;
    release dut.done_cnt;
    enable = 1'b1;
    i0 = irq_n;
    push_one(32'hC00, 32'hC04);
    serve(1, 2);
    step(5);
    chk("t5 done_cnt wrap", done_cnt, 0);
    chk("t5 irq", irq_n - i0, 1);

    // START with busy never rising
    s0 = start_hi;
    push_one(32'hD00, 32'hD04);
    wait_start();
    step(20);
`ifdef CODMA_TQ_START_TIMEOUT_EN
    chk("t6 start cycles", start_hi - s0, START_TIMEOUT);
    chk("t6 err", err_o, 1);
    chk("t6 start dropped", start_o, 0);
`else
    chk("t6 start waits", start_o, 1);
    chk("t6 err tied", err_o, 0);
    busy = 1'b1; step(2); busy = 1'b0;
    step(4);
`endif

    // reset mid-RUN
    push_one(32'hE00, 32'hE04);
    push_one(32'hF00, 32'hF04);
    wait_start();
    step(); busy = 1'b1;
    step(2);
    reset = 1'b1; step(); reset = 1'b0;
    chk("t7 start", start_o, 0);
    chk("t7 stop", stop_o, 0);
    chk("t7 irq", irq_o, 0);
    chk("t7 err", err_o, 0);
    chk("t7 level", level, 0);
    chk("t7 push_ready", push_ready, 1);
    chk("t7 task_ptr", task_pointer, 0);
    chk("t7 done_cnt", done_cnt, 0);
    busy = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
